// File: rtl/intr_ctrl_if.sv
// Register bus and CPU interrupt handshake for intr_ctrl.
// master = CPU/bus side, slave = the controller.
interface intr_ctrl_if #(
    parameter int VEC_W = 16
);
    logic [2:0]       reg_addr;
    logic             reg_wr;
    logic [15:0]      reg_wdata;
    logic [15:0]      reg_rdata;
    logic             irq_out;
    logic             ack;
    logic             eoi;
    logic [VEC_W-1:0] vector;
    logic [3:0]       irq_id;

    modport master (
        output reg_addr, reg_wr, reg_wdata, ack, eoi,
        input  reg_rdata, irq_out, vector, irq_id
    );

    modport slave (
        input  reg_addr, reg_wr, reg_wdata, ack, eoi,
        output reg_rdata, irq_out, vector, irq_id
    );
endinterface

// File: rtl/intr_ctrl.sv
// Prioritised, nesting interrupt controller.
// Channel 0 has the highest priority. Edge channels latch rising edges into
// PEND; level channels mirror irq_in one cycle late.
module intr_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    intr_ctrl_if.slave         bus
);
    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_ENABLE = 3'd1,
        REG_MODE   = 3'd2,
        REG_PEND   = 3'd3,
        REG_INSVC  = 3'd4,
        REG_BASE   = 3'd5
    } reg_e;

    localparam int SUM_W = (VEC_W > 20) ? VEC_W : 20;

    logic               gie_q, gie_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] insvc_q, insvc_d;
    logic [NUM_IRQ-1:0] hist_q, hist_d;
    logic [15:0]        base_q, base_d;
    logic [VEC_W-1:0]   vector_q, vector_d;
    logic [3:0]         irq_id_q, irq_id_d;

    reg_e               addr;
    logic [NUM_IRQ-1:0] req, win_mask, svc_mask, ack_mask, eoi_mask, rise, w1c;
    logic [3:0]         win_idx, svc_idx;
    logic               win_vld, svc_vld, irq_out, do_ack;
    logic [SUM_W-1:0]   vec_sum;

    assign addr = reg_e'(bus.reg_addr);

    // Find the winning request and the highest-priority channel in service.
    always_comb begin
        req      = pend_q & enable_q;
        win_vld  = 1'b0;
        win_idx  = '0;
        win_mask = '0;
        svc_vld  = 1'b0;
        svc_idx  = '0;
        svc_mask = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (req[i] && !win_vld) begin
                win_vld     = 1'b1;
                win_idx     = 4'(i);
                win_mask[i] = 1'b1;
            end
            if (insvc_q[i] && !svc_vld) begin
                svc_vld     = 1'b1;
                svc_idx     = 4'(i);
                svc_mask[i] = 1'b1;
            end
        end
        irq_out = gie_q && win_vld && (!svc_vld || (win_idx < svc_idx));
    end

    // Next-state for registers, pending/in-service tracking and ack outputs.
    always_comb begin
        gie_d    = gie_q;
        enable_d = enable_q;
        mode_d   = mode_q;
        base_d   = base_q;
        vector_d = vector_q;
        irq_id_d = irq_id_q;
        hist_d   = irq_in;

        do_ack   = bus.ack && irq_out;
        ack_mask = do_ack ? win_mask : '0;
        eoi_mask = bus.eoi ? svc_mask : '0;
        rise     = irq_in & ~hist_q;
        w1c      = (bus.reg_wr && addr == REG_PEND) ? bus.reg_wdata[NUM_IRQ-1:0] : '0;
        vec_sum  = SUM_W'(base_q) + (SUM_W'(win_idx) << 2);

        if (bus.reg_wr) begin
            case (addr)
                REG_CTRL:   gie_d    = bus.reg_wdata[0];
                REG_ENABLE: enable_d = bus.reg_wdata[NUM_IRQ-1:0];
                REG_MODE:   mode_d   = bus.reg_wdata[NUM_IRQ-1:0];
                REG_BASE:   base_d   = bus.reg_wdata;
                default:    ;
            endcase
        end

        // Current mode_q selects behaviour, so a MODE write takes effect next
        // cycle. A new edge is OR'd in last so it beats W1C and ack clears.
        pend_d  = (mode_q & ((pend_q & ~w1c & ~ack_mask) | rise)) | (~mode_q & irq_in);
        // eoi uses the pre-edge in-service set; ack's new bit is OR'd after.
        insvc_d = (insvc_q & ~eoi_mask) | ack_mask;

        if (do_ack) begin
            irq_id_d = win_idx;
            vector_d = vec_sum[VEC_W-1:0];
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gie_q    <= 1'b0;
            enable_q <= '0;
            mode_q   <= '0;
            pend_q   <= '0;
            insvc_q  <= '0;
            hist_q   <= '0;
            base_q   <= '0;
            vector_q <= '0;
            irq_id_q <= '0;
        end else begin
            gie_q    <= gie_d;
            enable_q <= enable_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            insvc_q  <= insvc_d;
            hist_q   <= hist_d;
            base_q   <= base_d;
            vector_q <= vector_d;
            irq_id_q <= irq_id_d;
        end
    end

    // Register read mux; unmapped words and channel bits read as zero.
    always_comb begin
        bus.reg_rdata = '0;
        case (addr)
            REG_CTRL:   bus.reg_rdata = {15'b0, gie_q};
            REG_ENABLE: bus.reg_rdata = 16'(enable_q);
            REG_MODE:   bus.reg_rdata = 16'(mode_q);
            REG_PEND:   bus.reg_rdata = 16'(pend_q);
            REG_INSVC:  bus.reg_rdata = 16'(insvc_q);
            REG_BASE:   bus.reg_rdata = base_q;
            default:    bus.reg_rdata = '0;
        endcase
    end

    assign bus.irq_out = irq_out;
    assign bus.vector  = vector_q;
    assign bus.irq_id  = irq_id_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl: register-map vector table
// followed by hand-written interrupt sequences.
module tb_intr_ctrl;
    localparam int NIRQ = 8;

    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_EN    = 3'd1;
    localparam logic [2:0] A_MODE  = 3'd2;
    localparam logic [2:0] A_PEND  = 3'd3;
    localparam logic [2:0] A_INSVC = 3'd4;
    localparam logic [2:0] A_BASE  = 3'd5;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } reg_vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NIRQ-1:0] irq_in = '0;
    int              n_chk = 0;
    int              n_pass = 0;
    reg_vec_t        tbl[12];

    intr_ctrl_if #(.VEC_W(16)) bus ();

    intr_ctrl #(.NUM_IRQ(NIRQ), .VEC_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        bus.reg_wr    = 1'b1;
        step();
        bus.reg_wr    = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [2:0] a, input logic [15:0] exp);
        bus.reg_addr = a;
        #1;
        chk(nm, 32'(bus.reg_rdata), 32'(exp));
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask

    task automatic do_eoi();
        bus.eoi = 1'b1;
        step();
        bus.eoi = 1'b0;
    endtask

    task automatic edge_on(input int ch);
        irq_in[ch] = 1'b1;
        step();
        irq_in = '0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        irq_in = '0;
        bus.ack = 1'b0;
        bus.eoi = 1'b0;
        bus.reg_wr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{A_CTRL,  16'hFFFF, 16'h0001};
        tbl[1]  = '{A_CTRL,  16'hFFFE, 16'h0000};
        tbl[2]  = '{A_EN,    16'hFFFF, 16'h00FF};
        tbl[3]  = '{A_MODE,  16'hABCD, 16'h00CD};
        tbl[4]  = '{A_BASE,  16'h1234, 16'h1234};
        tbl[5]  = '{A_INSVC, 16'hFFFF, 16'h0000};
        tbl[6]  = '{A_PEND,  16'hFFFF, 16'h0000};
        tbl[7]  = '{3'd6,    16'hFFFF, 16'h0000};
        tbl[8]  = '{3'd7,    16'hFFFF, 16'h0000};
        tbl[9]  = '{A_EN,    16'h0000, 16'h0000};
        tbl[10] = '{A_MODE,  16'h0000, 16'h0000};
        tbl[11] = '{A_BASE,  16'h0000, 16'h0000};

        bus.reg_addr = '0;
        bus.reg_wdata = '0;
        bus.reg_wr = 1'b0;
        bus.ack = 1'b0;
        bus.eoi = 1'b0;

        // Reset state
        #2;
        chk("rst_irq_out", 32'(bus.irq_out), 0);
        chk("rst_vector", 32'(bus.vector), 0);
        chk("rst_irq_id", 32'(bus.irq_id), 0);
        @(negedge clk);
        rst = 1'b0;
        rd("rst_ctrl", A_CTRL, 16'h0000);

        // Register map table
        for (int i = 0; i < 12; i++) begin
            wr(tbl[i].addr, tbl[i].wdata);
            rd($sformatf("regmap[%0d]", i), tbl[i].addr, tbl[i].exp);
        end

        // Basic edge
        do_rst();
        wr(A_BASE, 16'h0300);
        wr(A_CTRL, 16'h0001);
        wr(A_EN, 16'h0004);
        wr(A_MODE, 16'h0004);
        chk("edge_idle", 32'(bus.irq_out), 0);
        edge_on(2);
        chk("edge_irq", 32'(bus.irq_out), 1);
        rd("edge_pend", A_PEND, 16'h0004);
        do_ack();
        chk("edge_vec", 32'(bus.vector), 32'h0308);
        chk("edge_id", 32'(bus.irq_id), 2);
        chk("edge_irq_ack", 32'(bus.irq_out), 0);
        rd("edge_pend_ack", A_PEND, 16'h0000);
        rd("edge_insvc", A_INSVC, 16'h0004);
        do_eoi();
        rd("edge_insvc_eoi", A_INSVC, 16'h0000);

        // Priority and nesting
        do_rst();
        wr(A_BASE, 16'h0300);
        wr(A_CTRL, 16'h0001);
        wr(A_EN, 16'h0062);
        wr(A_MODE, 16'h0062);
        edge_on(5);
        chk("nest_irq5", 32'(bus.irq_out), 1);
        do_ack();
        chk("nest_vec5", 32'(bus.vector), 32'h0314);
        chk("nest_id5", 32'(bus.irq_id), 5);
        edge_on(1);
        chk("nest_irq1", 32'(bus.irq_out), 1);
        do_ack();
        chk("nest_vec1", 32'(bus.vector), 32'h0304);
        chk("nest_id1", 32'(bus.irq_id), 1);
        rd("nest_insvc22", A_INSVC, 16'h0022);
        edge_on(6);
        chk("nest_irq6_blk", 32'(bus.irq_out), 0);
        rd("nest_pend6", A_PEND, 16'h0040);
        do_eoi();
        rd("nest_insvc20", A_INSVC, 16'h0020);
        chk("nest_irq6_blk2", 32'(bus.irq_out), 0);
        do_eoi();
        rd("nest_insvc00", A_INSVC, 16'h0000);
        chk("nest_irq6", 32'(bus.irq_out), 1);
        do_ack();
        chk("nest_vec6", 32'(bus.vector), 32'h0318);
        do_eoi();
        do_eoi();
        rd("nest_eoi_empty", A_INSVC, 16'h0000);
        chk("nest_id_hold", 32'(bus.irq_id), 6);

        // Level channel
        do_rst();
        wr(A_CTRL, 16'h0001);
        wr(A_EN, 16'h0001);
        irq_in[0] = 1'b1;
        step();
        chk("lvl_irq", 32'(bus.irq_out), 1);
        do_ack();
        chk("lvl_irq_ack", 32'(bus.irq_out), 0);
        rd("lvl_pend_held", A_PEND, 16'h0001);
        rd("lvl_insvc", A_INSVC, 16'h0001);
        do_eoi();
        chk("lvl_irq_again", 32'(bus.irq_out), 1);
        irq_in[0] = 1'b0;
        step();
        rd("lvl_pend_drop", A_PEND, 16'h0000);
        chk("lvl_irq_drop", 32'(bus.irq_out), 0);

        // Collisions
        do_rst();
        wr(A_CTRL, 16'h0001);
        wr(A_EN, 16'h000A);
        wr(A_MODE, 16'h000A);
        edge_on(3);
        step();
        rd("col_pend3", A_PEND, 16'h0008);
        irq_in[3] = 1'b1;
        wr(A_PEND, 16'h0008);
        irq_in = '0;
        rd("col_w1c_vs_edge", A_PEND, 16'h0008);
        step();
        wr(A_PEND, 16'h0008);
        rd("col_w1c", A_PEND, 16'h0000);
        edge_on(3);
        do_ack();
        rd("col_insvc3", A_INSVC, 16'h0008);
        edge_on(1);
        chk("col_irq1", 32'(bus.irq_out), 1);
        bus.ack = 1'b1;
        bus.eoi = 1'b1;
        step();
        bus.ack = 1'b0;
        bus.eoi = 1'b0;
        rd("col_ack_eoi", A_INSVC, 16'h0002);
        chk("col_ack_eoi_id", 32'(bus.irq_id), 1);
        do_eoi();
        edge_on(1);
        step();
        irq_in[1] = 1'b1;
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        irq_in = '0;
        rd("col_ack_vs_edge_pend", A_PEND, 16'h0002);
        rd("col_ack_vs_edge_svc", A_INSVC, 16'h0002);

        // Gating
        do_rst();
        wr(A_EN, 16'h0010);
        wr(A_MODE, 16'h0010);
        edge_on(4);
        chk("gate_gie0", 32'(bus.irq_out), 0);
        rd("gate_pend", A_PEND, 16'h0010);
        do_ack();
        rd("gate_ack_insvc", A_INSVC, 16'h0000);
        rd("gate_ack_pend", A_PEND, 16'h0010);
        chk("gate_ack_id", 32'(bus.irq_id), 0);
        wr(A_CTRL, 16'h0001);
        chk("gate_gie1", 32'(bus.irq_out), 1);
        wr(A_EN, 16'h0000);
        chk("gate_en0", 32'(bus.irq_out), 0);
        rd("gate_en0_pend", A_PEND, 16'h0010);

        // Reset mid-service
        do_rst();
        wr(A_BASE, 16'h0100);
        wr(A_CTRL, 16'h0001);
        wr(A_EN, 16'h0013);
        wr(A_MODE, 16'h0013);
        edge_on(1);
        do_ack();
        edge_on(0);
        do_ack();
        edge_on(4);
        rd("pre_rst_insvc", A_INSVC, 16'h0003);
        rd("pre_rst_pend", A_PEND, 16'h0010);
        rst = 1'b1;
        #1;
        chk("arst_irq_out", 32'(bus.irq_out), 0);
        chk("arst_vector", 32'(bus.vector), 0);
        chk("arst_irq_id", 32'(bus.irq_id), 0);
        rd("arst_insvc", A_INSVC, 16'h0000);
        rd("arst_pend", A_PEND, 16'h0000);
        rd("arst_base", A_BASE, 16'h0000);
        rd("arst_en", A_EN, 16'h0000);
        rd("arst_mode", A_MODE, 16'h0000);
        rd("arst_ctrl", A_CTRL, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        rd("arst_addr6", 3'd6, 16'h0000);
        rd("arst_addr7", 3'd7, 16'h0000);

        // Fresh service after reset without an eoi
        wr(A_CTRL, 16'h0001);
        wr(A_EN, 16'h0020);
        wr(A_MODE, 16'h0020);
        edge_on(5);
        chk("post_rst_irq", 32'(bus.irq_out), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameters SHALL be:
- NUM_IRQ, default 8: number of interrupt channels (1..16).
- VEC_W, default 16: vector width.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- irq_in  in  NUM_IRQ  request lines, synchronous to clk.
- reg_addr  in  3  register word index.
- reg_wr  in  1  register write strobe.
- reg_wdata  in  16  write data.
- reg_rdata  out  16  read data, combinational from reg_addr.
- irq_out  out  1  interrupt request to CPU.
- ack  in  1  CPU accepts interrupt (1-cycle pulse).
- eoi  in  1  CPU end of interrupt (IRET), 1-cycle pulse.
- vector  out  VEC_W  handler address of last acknowledged channel.
- irq_id  out  4  channel number of last acknowledged channel.

Function
REQ-003 Registers SHALL be, by reg_addr:
- 0 CTRL: bit0 GIE, RW.
- 1 ENABLE: RW, per channel.
- 2 MODE: RW; 1=edge, 0=level.
- 3 PEND: R; write-1-clear for edge channels only.
- 4 INSVC: RO.
- 5 BASE: RW.
- 6,7: read 0, writes ignored.
- Bits at or above NUM_IRQ: read 0, writes ignored.
REQ-004 Edge channel: rising edge (irq_in=1, previous sampled value=0) at clock edge N SHALL set PEND bit, visible cycle N+1.
REQ-005 Level channel: PEND bit SHALL equal irq_in registered each cycle.
REQ-006 Priority: lower channel index SHALL be higher priority.
REQ-007 irq_out SHALL be combinational from registers and SHALL be 1 iff all hold:
- GIE=1.
- Some bit of PEND&ENABLE is set.
- The highest-priority such bit outranks every set INSVC bit.
REQ-008 On ack with irq_out=1, at that clock edge, with c = winning channel:
- INSVC[c] SHALL set.
- irq_id SHALL become c.
- vector SHALL become BASE + 4*c, truncated to VEC_W.
- PEND[c] SHALL clear if c is edge mode.
REQ-009 ack with irq_out=0 SHALL have no effect.
REQ-010 On eoi, the highest-priority set INSVC bit SHALL clear; eoi with INSVC=0 SHALL have no effect.
REQ-011 ack and eoi in the same cycle SHALL both apply:
- eoi clears the highest INSVC bit from before the edge.
- ack sets its new bit.
- If both address the same bit, the bit ends set.
REQ-012 New edge and W1C of the same PEND bit in the same cycle: the edge SHALL win (bit stays 1).
REQ-013 ack clearing PEND[c] and a new edge on c in the same cycle: PEND[c] SHALL end 1.
REQ-014 Nesting: a higher-priority request SHALL reassert irq_out while a lower channel is in service; depth SHALL be bounded only by NUM_IRQ.
REQ-015 Clearing ENABLE or GIE SHALL NOT clear PEND or INSVC.
REQ-016 Changing MODE SHALL NOT alter PEND in that cycle; the new mode SHALL apply from the next cycle.

Reset
REQ-017 On rst, all of the following SHALL reset to 0 immediately and asynchronously:
- CTRL, ENABLE, MODE, PEND, INSVC, BASE.
- Edge-history flops, vector, irq_id, irq_out.
REQ-018 rst mid-service SHALL discard all in-service state; no eoi is required afterwards.

Verification
REQ-019 Basic edge:
- Stimulus: BASE=0x0300, GIE=1, ENABLE=0x04, MODE=0x04; pulse irq_in[2].
- Response: irq_out=1 next cycle; after ack, vector=0x0308, irq_id=2, PEND=0, INSVC=0x04, irq_out=0; after eoi, INSVC=0.
REQ-020 Priority/nesting:
- Stimulus: channel 5 in service; edge on ch1 -> irq_out=1; ack; then edge on ch6.
- Response: on ch1 ack, vector=BASE+4, INSVC=0x22; ch6 keeps irq_out=0 until two eoi pulses, INSVC 0x22 -> 0x20 -> 0x00.
REQ-021 Level:
- Stimulus: ch0 level, enabled, irq_in[0] held 1; ack then eoi.
- Response: after eoi, irq_out=1 again; after irq_in[0]=0, PEND[0]=0 one cycle later.
REQ-022 Collisions:
- Stimulus: W1C of PEND[3] and edge on ch3 in the same cycle.
- Response: PEND[3]=1.
- Stimulus: ack and eoi in the same cycle.
- Response: per REQ-011.
REQ-023 Gating:
- Stimulus: GIE=0 with ch4 pending and enabled.
- Response: irq_out=0, PEND[4]=1; set GIE=1 -> irq_out=1 next cycle.
- Stimulus: ack while irq_out=0.
- Response: no state change.
REQ-024 Reset:
- Stimulus: assert rst while INSVC=0x03 and PEND=0x10.
- Response: all registers and outputs 0 immediately; unmapped registers read 0 after reset.
